pc_fetch_ctrl: RTL and testbench

Program-counter and instruction-fetch controller for the MIPS datapath. Holds the PC, turns the next-PC byte address into a word index for instruction memory (byte address >> 2), runs a req/ack fetch handshake and presents one registered instruction at a time to decode. It consumes redirects from the control path. Jump targets arrive as the 28-bit word-aligned byte target already shifted left by 2; branch offsets arrive as sign-extended, already shifted byte offsets.

---
 rtl/pc_fetch_ctrl_pkg.sv | 19 +
 rtl/pc_fetch_ctrl_next_sel.sv | 30 +++
 rtl/pc_fetch_ctrl.sv | 116 +++++++++++
 tb/tb_pc_fetch_ctrl.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/pc_fetch_ctrl_pkg.sv
// Shared types and constants for the PC / fetch controller.
// Imported by the top and the next-PC selector.
package pc_fetch_ctrl_pkg;

  localparam int INSTR_W = 32;
  localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    HOLD  = 2'd1,
    FAULT = 2'd2
  } state_t;

  function automatic logic
    is_misaligned(input logic [1:0] lo);
    return lo != 2'b00;
  endfunction

endpackage

// File: rtl/pc_fetch_ctrl_next_sel.sv
// Next-PC selection: sequential, jump or taken branch.
// Flags targets that are not word aligned.
module pc_next_sel
  import pc_fetch_ctrl_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic [ADDR_W-1:0] pc_plus4,
  input  logic              jump_valid,
  input  logic [27:0]       jump_target,
  input  logic              branch_valid,
  input  logic [ADDR_W-1:0] branch_offset,
  output logic [ADDR_W-1:0] next_pc,
  output logic              misalign
);

  // Jump beats branch; branch wraps mod 2^ADDR_W.
  always_comb begin
    next_pc = pc_plus4;
    if (jump_valid) begin
      next_pc = {pc_plus4[ADDR_W-1:28],
                 jump_target};
    end else if (branch_valid) begin
      next_pc = pc_plus4 + branch_offset;
    end
  end

  assign misalign = is_misaligned(next_pc[1:0]);

endmodule

// File: rtl/pc_fetch_ctrl.sv
// PC register, fetch handshake and instruction hold.
// One instruction presented per fetch; misaligned redirect locks up.
module pc_fetch_ctrl
  import pc_fetch_ctrl_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int IMEM_AW = 10,
  parameter logic [ADDR_W-1:0] RESET_PC =
    ADDR_W'(RESET_PC_DEF)
) (
  input  logic               Clk,
  input  logic               Rst,
  input  logic               stall,
  input  logic               jump_valid,
  input  logic [27:0]        jump_target,
  input  logic               branch_valid,
  input  logic [ADDR_W-1:0]  branch_offset,
  output logic               imem_req,
  output logic [IMEM_AW-1:0] imem_word_addr,
  input  logic               imem_ack,
  input  logic [INSTR_W-1:0] imem_rdata,
  output logic               instr_valid,
  output logic [INSTR_W-1:0] instr,
  output logic [ADDR_W-1:0]  pc,
  output logic [ADDR_W-1:0]  pc_plus4,
  output logic               misalign_fault
);

  state_t state;
  state_t state_n;
  logic load;
  logic retire;
  logic [ADDR_W-1:0] next_pc;
  logic misalign;

  assign pc_plus4 = pc + ADDR_W'(4);
  assign imem_word_addr = pc[IMEM_AW+1:2];

  // Reset gates the request so it drops the moment Rst rises.
  assign imem_req = (state == FETCH) & ~Rst;

  pc_next_sel #(
    .ADDR_W(ADDR_W)
  ) u_next_sel (
    .pc_plus4     (pc_plus4),
    .jump_valid   (jump_valid),
    .jump_target  (jump_target),
    .branch_valid (branch_valid),
    .branch_offset(branch_offset),
    .next_pc      (next_pc),
    .misalign     (misalign)
  );

  // State register.
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      state <= FETCH;
    end else begin
      state <= state_n;
    end
  end

  // Next state and datapath strobes.
  always_comb begin
    state_n = state;
    load    = 1'b0;
    retire  = 1'b0;
    case (state)
      FETCH: begin
        if (imem_ack) begin
          load    = 1'b1;
          state_n = HOLD;
        end
      end
      HOLD: begin
        if (!stall) begin
          retire  = 1'b1;
          state_n = misalign ? FAULT : FETCH;
        end
      end
      FAULT: begin
        state_n = FAULT;
      end
      default: begin
        state_n = FETCH;
      end
    endcase
  end

  // Capture the fetched word; clear it as it retires.
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      instr       <= '0;
      instr_valid <= 1'b0;
    end else if (load) begin
      instr       <= imem_rdata;
      instr_valid <= 1'b1;
    end else if (retire) begin
      instr_valid <= 1'b0;
    end
  end

  // PC advances on retire; a bad target stays visible in pc.
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      pc             <= RESET_PC;
      misalign_fault <= 1'b0;
    end else if (retire) begin
      pc <= next_pc;
      if (misalign) begin
        misalign_fault <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// Bench for pc_fetch_ctrl: directed pins plus random traffic
// compared every cycle against a behavioural model.
module tb_pc_fetch_ctrl;

  logic        Clk = 1'b0;
  logic        Rst = 1'b1;
  logic        stall = 1'b1;
  logic        jv = 1'b0;
  logic [27:0] jt = '0;
  logic        bv = 1'b0;
  logic [31:0] off = '0;
  logic        ack = 1'b0;
  logic [31:0] rdata = '0;
  logic        imem_req;
  logic [9:0]  waddr;
  logic        instr_valid;
  logic [31:0] instr;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic        fault;

  int tests = 0;
  int fails = 0;

  localparam int PH_F = 0;
  localparam int PH_H = 1;
  localparam int PH_X = 2;

  int          m_ph = PH_F;
  logic [31:0] m_pc = '0;
  logic [31:0] m_instr = '0;
  logic        m_val = 1'b0;
  logic        m_flt = 1'b0;

  pc_fetch_ctrl dut (
    .Clk           (Clk),
    .Rst           (Rst),
    .stall         (stall),
    .jump_valid    (jv),
    .jump_target   (jt),
    .branch_valid  (bv),
    .branch_offset (off),
    .imem_req      (imem_req),
    .imem_word_addr(waddr),
    .imem_ack      (ack),
    .imem_rdata    (rdata),
    .instr_valid   (instr_valid),
    .instr         (instr),
    .pc            (pc),
    .pc_plus4      (pc_plus4),
    .misalign_fault(fault)
  );

  always #5 Clk = ~Clk;

  task automatic chk(input string n,
                     input logic [31:0] a,
                     input logic [31:0] e);
    tests++;
    if (a !== e) begin
      fails++;
      $display("FAIL %s: got %h want %h", n, a, e);
    end
  endtask

  // Model: step on each edge, then compare all outputs.
  always @(posedge Clk or posedge Rst) begin
    logic [31:0] p4;
    logic [31:0] np;
    if (Rst) begin
      m_ph = PH_F; m_pc = 0; m_instr = 0;
      m_val = 0; m_flt = 0;
    end else if (m_ph == PH_F) begin
      if (ack) begin
        m_instr = rdata; m_val = 1; m_ph = PH_H;
      end
    end else if (m_ph == PH_H && !stall) begin
      p4 = m_pc + 32'd4;
      if (jv) np = {p4[31:28], jt};
      else if (bv) np = p4 + off;
      else np = p4;
      m_pc = np;
      m_val = 0;
      if (np % 4 != 0) begin
        m_flt = 1; m_ph = PH_X;
      end else begin
        m_ph = PH_F;
      end
    end
    #1;
    chk("m_req", imem_req,
        32'(m_ph == PH_F && !Rst));
    chk("m_waddr", waddr, m_pc[11:2]);
    chk("m_valid", instr_valid, m_val);
    chk("m_instr", instr, m_instr);
    chk("m_pc", pc, m_pc);
    chk("m_pc4", pc_plus4, m_pc + 32'd4);
    chk("m_fault", fault, m_flt);
  end

  task automatic fetch_one(input logic [31:0] d);
    ack = 1; rdata = d; stall = 1;
    @(negedge Clk);
    ack = 0; rdata = $urandom;
  endtask

  task automatic retire(input logic j,
                        input logic [27:0] t,
                        input logic b,
                        input logic [31:0] o);
    stall = 0; jv = j; jt = t; bv = b; off = o;
    @(negedge Clk);
    stall = 1; jv = 0; bv = 0;
  endtask

  initial begin
    repeat (2) @(negedge Clk);
    chk("rst_req", imem_req, 0);
    chk("rst_valid", instr_valid, 0);
    chk("rst_instr", instr, 0);
    chk("rst_pc", pc, 0);
    chk("rst_fault", fault, 0);

    Rst = 0; ack = 1; rdata = 32'h2008_0005;
    #1;
    chk("first_req", imem_req, 1);
    chk("first_waddr", waddr, 0);
    @(negedge Clk);
    ack = 0;
    chk("first_valid", instr_valid, 1);
    chk("first_instr", instr, 32'h2008_0005);
    chk("first_pc", pc, 0);
    chk("hold_req", imem_req, 0);
    retire(0, 0, 0, 0);
    chk("seq_waddr", waddr, 10'd1);
    chk("seq_req", imem_req, 1);

    fetch_one($urandom);
    retire(1, 28'h40, 0, 0);
    chk("j40_pc", pc, 32'h40);
    fetch_one($urandom);
    retire(1, 28'h100, 0, 0);
    chk("j100_pc", pc, 32'h100);
    chk("j100_waddr", waddr, 10'h040);
    fetch_one($urandom);
    retire(1, 28'h40, 0, 0);
    fetch_one($urandom);
    retire(0, 0, 1, 32'hFFFF_FFF0);
    chk("br_pc", pc, 32'h34);
    fetch_one($urandom);
    retire(1, 28'h40, 0, 0);
    fetch_one($urandom);
    retire(1, 28'h80, 1, 32'hFFFF_FFF0);
    chk("jprio_pc", pc, 32'h80);

    fetch_one(32'hCAFE_0001);
    repeat (5) begin
      ack = 1; rdata = $urandom;
      @(negedge Clk);
      chk("stall_instr", instr, 32'hCAFE_0001);
      chk("stall_pc", pc, 32'h80);
      chk("stall_valid", instr_valid, 1);
      chk("stall_req", imem_req, 0);
    end
    ack = 0;
    retire(0, 0, 0, 0);
    repeat (3) begin
      rdata = $urandom;
      @(negedge Clk);
      chk("wait_waddr", waddr, 10'h021);
      chk("wait_req", imem_req, 1);
    end
    fetch_one(32'h1234_5678);
    chk("late_instr", instr, 32'h1234_5678);
    chk("late_valid", instr_valid, 1);

    retire(0, 0, 1, 32'h2);
    chk("mis_fault", fault, 1);
    chk("mis_pc", pc, 32'h8A);
    chk("mis_req", imem_req, 0);
    chk("mis_valid", instr_valid, 0);
    repeat (4) begin
      ack = 1; stall = 0;
      @(negedge Clk);
      chk("flt_hold", fault, 1);
      chk("flt_req", imem_req, 0);
    end
    ack = 0; stall = 1;
    Rst = 1;
    #1;
    chk("clr_fault", fault, 0);
    chk("clr_pc", pc, 0);
    @(negedge Clk);
    Rst = 0;

    @(negedge Clk);
    Rst = 1;
    #1;
    chk("arst_req", imem_req, 0);
    ack = 1; rdata = 32'hDEAD_BEEF;
    @(negedge Clk);
    chk("arst_valid", instr_valid, 0);
    chk("arst_instr", instr, 0);
    Rst = 0; ack = 0;
    #1;
    chk("arst_rereq", imem_req, 1);
    chk("arst_pc", pc, 0);
    @(negedge Clk);

    repeat (3000) begin
      Rst = ((m_flt && $urandom_range(0, 3) == 0)
             || $urandom_range(0, 99) == 0);
      stall = ($urandom_range(0, 9) < 3);
      ack = $urandom_range(0, 1) == 1;
      rdata = $urandom;
      jv = ($urandom_range(0, 4) == 0);
      jt = 28'($urandom) & 28'hFFF_FFFC;
      if ($urandom_range(0, 39) == 0)
        jt[1:0] = 2'($urandom_range(1, 3));
      bv = ($urandom_range(0, 3) == 0);
      off = 32'($urandom_range(0, 64)) << 2;
      if ($urandom_range(0, 1) == 1) off = -off;
      if ($urandom_range(0, 39) == 0)
        off = off + 32'd2;
      @(negedge Clk);
    end
    Rst = 0;
    @(negedge Clk);
    $display("[TB] %0d tests run, %0d failed",
             tests, fails);
    $finish;
  end

endmodule
